// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream bundle carrying the FIFO payload plus a packet-last marker.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a full-throughput valid/ready stream
// through a head/skid buffer. Define FIFO_RD_PKT_LAST_EN to enable m_last packet marking.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_stream_reader_if.master  m
);

  if (PKT_LEN < 1) begin : g_pkt_len_invalid
    $error("PKT_LEN must be >= 1");
  end

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic [1:0]            occ_q, occ_d, occ_pop;
  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic [2:0]            level;

  assign m.m_valid = (occ_q != 2'd0);
  assign m.m_data  = head_q;
  assign pop       = m.m_valid && m.m_ready;

  // Slots committed after this edge: buffered + returning word - word leaving now.
  assign level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = rst_n && !flush && !fifo_empty && (level < 3'd2);

  always_comb begin
    occ_pop    = occ_q - {1'b0, pop};
    head_d     = pop ? skid_q : head_q;
    skid_d     = skid_q;
    occ_d      = occ_pop;
    inflight_d = fifo_rd_en;
    if (inflight_q) begin
      if (occ_pop == 2'd0) head_d = fifo_data_out;
      else                 skid_d = fifo_data_out;
      occ_d = occ_pop + 2'd1;
    end
    if (flush) begin
      head_d     = head_q;
      skid_d     = skid_q;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_RD_PKT_LAST_EN
  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Gated by m_valid so PKT_LEN=1 still reads 0 when nothing is presented.
  assign m.m_last = m.m_valid && (cnt_q == CW'(PKT_LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (flush)    cnt_d = '0;
    else if (pop) cnt_d = m.m_last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign m.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a behavioural FIFO feeds the DUT, expected
// beats are queued at load time and a monitor checks every handshake.
module tb_fifo_stream_reader;

`ifdef FIFO_RD_PKT_LAST_EN
  localparam bit PKT_EN = 1'b1;
`else
  localparam bit PKT_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fifo_empty;
  logic [63:0] fifo_data_out = '0;
  logic        fifo_rd_en;

  fifo_stream_reader_if #(.DATA_WIDTH(64)) m_if ();

  fifo_stream_reader #(.DATA_WIDTH(64), .PKT_LEN(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en   (fifo_rd_en),
    .m            (m_if)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data appears the cycle after an accepted read.
  logic [63:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= mem[rd_ptr[6:0]];
      rd_ptr        <= rd_ptr + 1;
      rd_cnt        <= rd_cnt + 1;
    end
  end

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          pop_cnt = 0;
  int          discard = 0;
  logic [15:0] pat = 16'b1011_0111_1100_1101;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic lastof(input int i);
    return PKT_EN && ((i % 4) == 3);
  endfunction

  task automatic load(input logic [63:0] v, input bit push, input logic last);
    exp_t e;
    mem[wr_ptr[6:0]] = v;
    wr_ptr++;
    if (push) begin
      e.d = v;
      e.l = last;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic monitor();
    exp_t        e;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    forever begin
      @(negedge clk);
      chk("occ_le2", 64'((rd_cnt - pop_cnt - discard) <= 2), 64'd1);
      if (prev_stall && m_if.m_valid) begin
        chk("hold_data", m_if.m_data, prev_data);
        chk("hold_last", 64'(m_if.m_last), 64'(prev_last));
      end
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_if.m_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_if.m_data, e.d);
          chk("last", 64'(m_if.m_last), 64'(e.l));
        end
        pop_cnt++;
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_data  = m_if.m_data;
      prev_last  = m_if.m_last;
    end
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    flush = 1'b0;
    m_if.m_ready = 1'b0;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    #12;
    chk("rst_m_valid", 64'(m_if.m_valid), 64'd0);
    chk("rst_m_data", m_if.m_data, 64'd0);
    chk("rst_m_last", 64'(m_if.m_last), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rd_en", 64'(fifo_rd_en), 64'd0);

    // Streaming: latency of two edges, then 8 back-to-back beats
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) load(64'(i + 1), 1'b1, lastof(i));
    #1 chk("stream_rd_en", 64'(fifo_rd_en), 64'd1);
    @(posedge clk); #1 chk("stream_lat_valid", 64'(m_if.m_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 chk("stream_valid", 64'(m_if.m_valid), 64'd1);
    end
    wait_drain("stream_drain", 20);

    // Backpressure: 5 stalled edges, exactly 2 reads, head holds first word
    @(posedge clk); #1 m_if.m_ready = 1'b0;
    @(negedge clk);
    base = rd_cnt;
    for (int i = 0; i < 8; i++) load(64'h11 + 64'(i), 1'b1, lastof(i));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_reads", 64'(rd_cnt - base), 64'd2);
    chk("bp_head", m_if.m_data, 64'h11);
    chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1 m_if.m_ready = 1'b1;
    #1 chk("bp_resume", 64'(fifo_rd_en), 64'd1);
    wait_drain("bp_drain", 40);

    // Alternating ready over 16 words
    @(negedge clk);
    for (int i = 0; i < 16; i++) load(64'h21 + 64'(i), 1'b1, lastof(i));
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1 m_if.m_ready = !m_if.m_ready;
    end
    chk("alt_drain", 64'(exp_q.size()), 64'd0);

    // Flush with one word buffered and one in flight: 0x41/0x42 are lost
    @(posedge clk); #1 m_if.m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load(64'h41, 1'b0, 1'b0);
    load(64'h42, 1'b0, 1'b0);
    load(64'h43, 1'b1, lastof(0));
    load(64'h44, 1'b1, lastof(1));
    @(posedge clk);
    @(posedge clk); #1 flush = 1'b1;
    #1 chk("flush_pre_valid", 64'(m_if.m_valid), 64'd1);
    chk("flush_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    discard += 2;
    chk("flush_valid", 64'(m_if.m_valid), 64'd0);
    m_if.m_ready = 1'b1;
    wait_drain("flush_drain", 20);

    // Idle flush zeroes the packet counter
    @(posedge clk);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;

    // Packet marking under an irregular stall pattern
    @(negedge clk);
    for (int i = 0; i < 12; i++) load(64'h51 + 64'(i), 1'b1, lastof(i));
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1 m_if.m_ready = pat[c % 16];
    end
    chk("pkt_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream with 2 words buffered and a third still in the FIFO
    @(posedge clk); #1 m_if.m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load(64'h61, 1'b0, 1'b0);
    load(64'h62, 1'b0, 1'b0);
    load(64'h63, 1'b1, lastof(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst2_pre_valid", 64'(m_if.m_valid), 64'd1);
    chk("rst2_pre_data", m_if.m_data, 64'h61);
    chk("rst2_pre_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    discard += 2;
    #1;
    chk("rst2_m_valid", 64'(m_if.m_valid), 64'd0);
    chk("rst2_m_data", m_if.m_data, 64'd0);
    chk("rst2_m_last", 64'(m_if.m_last), 64'd0);
    chk("rst2_rd_en", 64'(fifo_rd_en), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_if.m_ready = 1'b1;
    wait_drain("rst2_drain", 20);
    repeat (4) begin
      @(negedge clk);
      chk("empty_rd_en", 64'(fifo_rd_en), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
